bambu_getchar_ext: RTL and testbench
====================================

# bambu_getchar_ext

Parametrised hardware IP for the `bambu_getchar()` family of calls. Received bytes from the UART receive side (`RX_DATA`/`RX_VALID`) are buffered in a FIFO of configurable width and depth. Each Bambu call handshake (`start_port`/`done_port`) returns one character. It extends the blocking single-byte reader with:
- a per-call non-blocking mode,
- an optional blocking timeout that returns EOF,
- overflow/drop accounting and an exposed fill level.

## Interface
Parameters:
- `DATA_WIDTH`, 8: character width on `RX_DATA`.
- `RET_WIDTH`, 32: width of `return_port`, matching a C `int` return. Must be > `DATA_WIDTH`.
- `DEPTH_LOG2`, 4: FIFO depth is 2^`DEPTH_LOG2` entries.
- `TIMEOUT_CYCLES`, 0: blocking-call timeout in cycles. 0 means wait forever.
- `DROP_CNT_WIDTH`, 16: width of the dropped-character counter.

Ports:
- `clock`  in  1  single clock; everything is sampled on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_port`  in  1  call request; sampled only in IDLE.
- `nonblock_port`  in  1  call argument, sampled together with `start_port`. 1 = non-blocking call.
- `done_port`  out  1  one-cycle pulse marking call completion.
- `return_port`  out  `RET_WIDTH`  zero-extended character, or all-ones (-1, EOF).
- `RX_DATA`  in  `DATA_WIDTH`  received character.
- `RX_VALID`  in  1  one-cycle strobe that qualifies `RX_DATA`.
- `rx_overflow`  out  1  sticky flag: at least one character has been dropped since reset.
- `drop_count`  out  `DROP_CNT_WIDTH`  saturating count of dropped characters.
- `fill_level`  out  `DEPTH_LOG2`+1  current FIFO occupancy.

## Operation
- **Capture path.**
  - `RX_VALID`=1 with the FIFO not full: the character is written the same cycle. There is no holding register, so back-to-back strobes are accepted.
  - `RX_VALID`=1 with the FIFO full: the character is dropped. `drop_count` increments and saturates at all-ones. `rx_overflow` is set.
  - A read in the same cycle does not free a slot for a write into a full FIFO; the write is still dropped.
- **Read FSM** has four states: IDLE, WAIT, CAPTURE, DONE.
  - IDLE: `start_port`=1 → WAIT. `nonblock_port` is latched and the timeout counter is cleared.
  - WAIT, FIFO not empty: assert the FIFO read enable (combinational from state) → CAPTURE with eof=0.
  - WAIT, FIFO empty, non-blocking call → CAPTURE with eof=1.
  - WAIT, FIFO empty, blocking call, `TIMEOUT_CYCLES`>0 and counter = `TIMEOUT_CYCLES`-1 → CAPTURE with eof=1.
  - WAIT, otherwise: the counter increments and the FSM stays in WAIT.
  - CAPTURE: load `return_port` with either the zero-extended FIFO read data or all-ones (if eof=1). Assert `done_port` → DONE.
  - DONE: deassert `done_port` → IDLE.
- `start_port` outside IDLE is ignored; no call is queued.
- `return_port` holds its value until the next completion.
- A non-blocking call on a non-empty FIFO behaves exactly like a blocking call.

## Timing
- Reset values:
  - `done_port`=0, `return_port`=0, `rx_overflow`=0, `drop_count`=0, `fill_level`=0.
  - FSM in IDLE, FIFO flushed.
- Reset mid-call aborts the call. No `done_port` is produced for the aborted call.
- Start sampled in cycle t with data available: read enable in t+1, `done_port`=1 and valid `return_port` in cycle t+3. This 3-cycle minimum is also the non-blocking EOF latency.
- Blocking call with timeout T and a FIFO that stays empty: `done_port` in cycle t+T+2 with `return_port` = all-ones.
- A character written in cycle w is readable (FIFO not empty) from cycle w+1.
- `fill_level` reflects writes and reads after the clock edge. A simultaneous read and write leave it unchanged.
- Minimum spacing between completions: IDLE → new start gives `done_port` every 4 cycles.

## Structure
- Shared package `bambu_io_pkg`:
  - FSM state encoding: one-hot, 4 bits.
  - EOF constant.
  - Default width parameters, shared with the putchar-side blocks.
- Sub-module: the existing `sync_fifo`, instantiated with `width`=`DATA_WIDTH`, depth 2^`DEPTH_LOG2`, and registered read data (data valid the cycle after read enable). `fill_level` is driven from its `count` output.
- Everything else is local logic in this block: capture/drop logic, read FSM, timeout counter.

## Test plan
- **Basic read.** Push 0x41. Start with `nonblock_port`=0 three cycles later → `done_port` 3 cycles after start, `return_port`=0x00000041, `fill_level` back to 0.
- **Non-blocking on empty.** Start with `nonblock_port`=1 on an empty FIFO → `return_port`=0xFFFFFFFF at start+3. Then push 0x7A and start again → 0x0000007A.
- **Timeout.** `TIMEOUT_CYCLES`=10, FIFO empty, blocking start → `done_port` exactly at start+12 with all-ones.
- **Timeout disabled.** `TIMEOUT_CYCLES`=0, blocking start → still waiting after 1000 cycles. Push 0x30 → done 2 cycles later with 0x30.
- **Overflow.** `DEPTH_LOG2`=2. Push 0x01 through 0x06 back-to-back → `fill_level`=4, `drop_count`=2, `rx_overflow`=1. Four reads return 0x01 to 0x04 in order. A simultaneous read+write while full still drops the write.
- **Reset mid-call.** Pulse `reset` while in WAIT → no `done_port`, outputs at reset values, FIFO empty. The next call behaves normally.

Source files
------------

// File: rtl/bambu_io_pkg.sv
// bambu_io_pkg: shared state encoding, EOF value and default widths for the bambu I/O blocks
package bambu_io_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_WAIT    = 4'b0010,
      S_CAPTURE = 4'b0100,
      S_DONE    = 4'b1000
   } rd_state_e;

   localparam int EOF_VAL            = -1;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_RET_WIDTH      = 32;
   localparam int DEF_DEPTH_LOG2     = 4;
   localparam int DEF_DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock power-of-two FIFO with registered read data and occupancy count
module sync_fifo #(
   parameter int width = 8,
   parameter int depth = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [width-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);

   localparam int AW = $clog2(depth);

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [width-1:0] rd_data_q, rd_data_d;
   logic             wr_ok, rd_ok;

   assign full    = count_q == (AW+1)'(depth);
   assign empty   = count_q == '0;
   assign wr_ok   = wr_en & ~full;
   assign rd_ok   = rd_en & ~empty;
   assign count   = count_q;
   assign rd_data = rd_data_q;

   always_comb begin
      wr_ptr_d  = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      rd_data_d = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
   end

   always_ff @(posedge clock) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

endmodule

// File: rtl/bambu_getchar_ext.sv
// bambu_getchar_ext: FIFO-buffered getchar with non-blocking mode, optional timeout and drop accounting
module bambu_getchar_ext import bambu_io_pkg::*; #(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int RET_WIDTH      = DEF_RET_WIDTH,
   parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start_port,
   input  logic                      nonblock_port,
   output logic                      done_port,
   output logic [RET_WIDTH-1:0]      return_port,
   input  logic [DATA_WIDTH-1:0]     RX_DATA,
   input  logic                      RX_VALID,
   output logic                      rx_overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_count,
   output logic [DEPTH_LOG2:0]       fill_level
);

   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

   rd_state_e               state_q, state_d;
   logic                    nb_q, nb_d, eof_q, eof_d, done_q, done_d, ovf_q, ovf_d;
   logic [TW-1:0]           cnt_q, cnt_d;
   logic [RET_WIDTH-1:0]    ret_q, ret_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic                    wr_en, rd_en, full, empty, timeout_hit;
   logic [DATA_WIDTH-1:0]   rd_data;

   // A full FIFO drops the incoming byte even if a read happens the same cycle
   assign wr_en       = RX_VALID & ~full;
   assign rd_en       = (state_q == S_WAIT) & ~empty;
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

   sync_fifo #(.width(DATA_WIDTH), .depth(1 << DEPTH_LOG2)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (RX_DATA),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (fill_level)
   );

   always_comb begin
      state_d = state_q;
      nb_d    = nb_q;
      eof_d   = eof_q;
      cnt_d   = cnt_q;
      ret_d   = ret_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q | (RX_VALID & full);
      drop_d  = (RX_VALID & full & ~&drop_q) ? drop_q + 1'b1 : drop_q;
      case (state_q)
         S_IDLE: if (start_port) begin
            state_d = S_WAIT;
            nb_d    = nonblock_port;
            cnt_d   = '0;
         end
         S_WAIT: begin
            if (!empty || nb_q || timeout_hit) begin
               state_d = S_CAPTURE;
               eof_d   = empty;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_CAPTURE: begin
            ret_d   = eof_q ? RET_WIDTH'(EOF_VAL) : RET_WIDTH'(rd_data);
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         nb_q    <= 1'b0;
         eof_q   <= 1'b0;
         cnt_q   <= '0;
         ret_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         nb_q    <= nb_d;
         eof_q   <= eof_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign done_port   = done_q;
   assign return_port = ret_q;
   assign rx_overflow = ovf_q;
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_bambu_getchar_ext.sv
// tb_bambu_getchar_ext: two configurations (depth 4 / timeout 10, depth 16 / no timeout) against a queue model
module tb_bambu_getchar_ext;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_i [2], nb_i [2], rxv_i [2];
   logic [7:0]  rxd_i [2];
   logic        done_o [2], ovf_o [2];
   logic [31:0] ret_o [2];
   logic [15:0] drop_o [2];
   logic [2:0]  fill_a;
   logic [4:0]  fill_b;

   bambu_getchar_ext #(.DEPTH_LOG2(2), .TIMEOUT_CYCLES(10)) dut_a (
      .clock(clk), .reset(rst), .start_port(start_i[0]), .nonblock_port(nb_i[0]),
      .done_port(done_o[0]), .return_port(ret_o[0]), .RX_DATA(rxd_i[0]), .RX_VALID(rxv_i[0]),
      .rx_overflow(ovf_o[0]), .drop_count(drop_o[0]), .fill_level(fill_a)
   );

   bambu_getchar_ext #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(0)) dut_b (
      .clock(clk), .reset(rst), .start_port(start_i[1]), .nonblock_port(nb_i[1]),
      .done_port(done_o[1]), .return_port(ret_o[1]), .RX_DATA(rxd_i[1]), .RX_VALID(rxv_i[1]),
      .rx_overflow(ovf_o[1]), .drop_count(drop_o[1]), .fill_level(fill_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a byte queue per instance, plus a call that waits, then shows done two edges after it resolves
   int          depth_m [2] = '{4, 16};
   int          tmo_m [2]   = '{10, 0};
   logic [7:0]  mq [2][$];
   bit          m_done [2], m_ovf [2], waiting [2], mnb [2];
   logic [31:0] m_ret [2] = '{0, 0};
   logic [31:0] pend [2];
   int          m_drop [2], waited [2], cd [2];
   bit          m_idle, m_full, m_empty;

   initial forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mq[i].delete();
            m_done[i] = 0; m_ret[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
            waiting[i] = 0; cd[i] = 0;
         end else begin
            m_idle  = !waiting[i] && cd[i] == 0;
            m_full  = mq[i].size() == depth_m[i];
            m_empty = mq[i].size() == 0;
            if (cd[i] > 0) begin
               cd[i]--;
               if (cd[i] == 1) begin m_done[i] = 1; m_ret[i] = pend[i]; end
               else m_done[i] = 0;
            end
            if (waiting[i]) begin
               if (!m_empty) begin
                  pend[i] = {24'h0, mq[i].pop_front()};
                  waiting[i] = 0; cd[i] = 2;
               end else if (mnb[i] || (tmo_m[i] > 0 && waited[i] == tmo_m[i] - 1)) begin
                  pend[i] = 32'hFFFF_FFFF;
                  waiting[i] = 0; cd[i] = 2;
               end else waited[i]++;
            end
            if (m_idle && start_i[i]) begin
               waiting[i] = 1; waited[i] = 0; mnb[i] = nb_i[i];
            end
            if (rxv_i[i]) begin
               if (!m_full) mq[i].push_back(rxd_i[i]);
               else begin
                  m_ovf[i] = 1;
                  m_drop[i] = m_drop[i] == 65535 ? 65535 : m_drop[i] + 1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("done[%0d]", i), done_o[i], m_done[i]);
         chk($sformatf("ret[%0d]", i), ret_o[i], m_ret[i]);
         chk($sformatf("ovf[%0d]", i), ovf_o[i], m_ovf[i]);
         chk($sformatf("drop[%0d]", i), drop_o[i], m_drop[i]);
         chk($sformatf("fill[%0d]", i), i == 0 ? fill_a : fill_b, mq[i].size());
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int i, input logic [7:0] d);
      rxv_i[i] = 1'b1;
      rxd_i[i] = d;
      tick();
      rxv_i[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget, inout int lat);
      while (!done_o[i] && lat < budget) begin
         tick();
         lat++;
      end
      if (!done_o[i]) begin
         checks++;
         errors++;
         $display("FAIL wait_done[%0d]: no done within %0d cycles", i, budget);
      end
   endtask

   task automatic call(input int i, input bit nb, input int budget, output int lat, output logic [31:0] r);
      nb_i[i]    = nb;
      start_i[i] = 1'b1;
      tick();
      start_i[i] = 1'b0;
      nb_i[i]    = 1'b0;
      lat = 1;
      wait_done(i, budget, lat);
      r = ret_o[i];
   endtask

   int          lat;
   logic [31:0] r;
   bit          seen;

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_i[i] = 0; nb_i[i] = 0; rxv_i[i] = 0; rxd_i[i] = 0;
      end
      repeat (2) tick();
      chk("rst_done", done_o[0], 0);
      chk("rst_ret", ret_o[1], 0);
      chk("rst_fill", fill_b, 0);
      rst = 1'b0;
      tick();

      call(0, 0, 30, lat, r);
      chk("tmo_latency", lat, 12);
      chk("tmo_ret", r, 32'hFFFF_FFFF);
      tick();

      for (int k = 1; k <= 6; k++) begin
         rxv_i[0] = 1'b1;
         rxd_i[0] = 8'(k);
         tick();
      end
      rxv_i[0] = 1'b0;
      chk("ovf_fill", fill_a, 4);
      chk("ovf_drop", drop_o[0], 2);
      chk("ovf_flag", ovf_o[0], 1);

      start_i[0] = 1'b1;
      tick();
      start_i[0] = 1'b0;
      rxv_i[0] = 1'b1;
      rxd_i[0] = 8'h07;
      tick();
      rxv_i[0] = 1'b0;
      lat = 2;
      wait_done(0, 10, lat);
      chk("rdwr_latency", lat, 3);
      chk("rdwr_ret", ret_o[0], 32'h1);
      chk("rdwr_drop", drop_o[0], 3);
      chk("rdwr_fill", fill_a, 3);
      for (int k = 2; k <= 4; k++) begin
         tick();
         call(0, 0, 10, lat, r);
         chk("order_latency", lat, 3);
         chk("order_ret", r, k);
      end
      chk("drain_fill", fill_a, 0);

      push(1, 8'h41);
      repeat (2) tick();
      call(1, 0, 10, lat, r);
      chk("basic_latency", lat, 3);
      chk("basic_ret", r, 32'h41);
      chk("basic_fill", fill_b, 0);
      tick();

      call(1, 1, 10, lat, r);
      chk("nb_eof_latency", lat, 3);
      chk("nb_eof_ret", r, 32'hFFFF_FFFF);
      tick();
      push(1, 8'h7A);
      call(1, 1, 10, lat, r);
      chk("nb_data_latency", lat, 3);
      chk("nb_data_ret", r, 32'h7A);
      tick();

      start_i[1] = 1'b1;
      tick();
      start_i[1] = 1'b0;
      seen = 0;
      repeat (1000) begin
         if (done_o[1]) seen = 1;
         tick();
      end
      chk("no_timeout_1000", seen, 0);
      push(1, 8'h30);
      lat = 0;
      wait_done(1, 10, lat);
      chk("late_push_latency", lat, 2);
      chk("late_push_ret", ret_o[1], 32'h30);
      tick();

      start_i[1] = 1'b1;
      tick();
      start_i[1] = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("midrst_done", done_o[1], 0);
      chk("midrst_ret", ret_o[1], 0);
      chk("midrst_fill", fill_b, 0);
      chk("midrst_drop_a", drop_o[0], 0);
      chk("midrst_ovf_a", ovf_o[0], 0);
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         if (done_o[1]) seen = 1;
         tick();
      end
      chk("midrst_no_done", seen, 0);
      push(1, 8'h55);
      call(1, 0, 10, lat, r);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_ret", r, 32'h55);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
